// File: rtl/btn_cmd.sv
// Button input conditioning: 2-flop sync, per-bit debounce, press detect, move-code handshake.
// Optional auto-repeat while a single button stays held: define BTN_REPEAT_EN.
module btn_cmd #(
    parameter int DB_CYCLES     = 4,
    parameter int DB_W          = 8,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn,
    input  logic       ack,
    output logic       valid,
    output logic [2:0] code,
    output logic [4:0] db_btn
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [4:0]           sync1_q, sync2_q;
    logic [4:0][DB_W-1:0] cnt_q, cnt_d;
    logic [4:0]           db_q, db_d;
    logic [4:0]           db_dly_q;
    logic [4:0]           press;
    logic [2:0]           press_code;
    logic [1:0]           state_q, state_d;
    logic [2:0]           code_q, code_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            state_q  <= S_IDLE;
            code_q   <= '0;
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_q;
            state_q  <= state_d;
            code_q   <= code_d;
        end
    end

    // The counter measures how long sync has disagreed with the debounced level.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                db_d[i]  = ~db_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign press = db_q & ~db_dly_q;

    always_comb begin
        press_code = 3'd0;
        if (press[4])      press_code = 3'd5;
        else if (press[0]) press_code = 3'd1;
        else if (press[1]) press_code = 3'd2;
        else if (press[2]) press_code = 3'd3;
        else if (press[3]) press_code = 3'd4;
    end

`ifdef BTN_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_dis_q, rpt_dis_d;
    logic             rpt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
            rpt_dis_q <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_dis_q <= rpt_dis_d;
        end
    end

    // code_q is never 0 while in REL, so the shift is always in range.
    assign rpt_hit = (db_q == (5'd1 << (code_q - 3'd1)));
`else
    logic unused_rpt;
    assign unused_rpt = (REPEAT_CYCLES > 0);
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
`ifdef BTN_REPEAT_EN
        rpt_cnt_d = rpt_cnt_q;
        rpt_dis_d = rpt_dis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (press != '0) begin
                    code_d  = press_code;
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                if (ack) begin
                    state_d = (db_q == '0) ? S_IDLE : S_REL;
`ifdef BTN_REPEAT_EN
                    rpt_cnt_d = '0;
                    rpt_dis_d = 1'b0;
`endif
                end
            end
            S_REL: begin
                if (db_q == '0) begin
                    state_d = S_IDLE;
`ifdef BTN_REPEAT_EN
                end else if (!rpt_dis_q && rpt_hit) begin
                    if (rpt_cnt_q == RPT_LAST) begin
                        rpt_cnt_d = '0;
                        state_d   = S_PEND;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end else begin
                    rpt_cnt_d = '0;
                    rpt_dis_d = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign valid  = (state_q == S_PEND);
    assign code   = code_q;
    assign db_btn = db_q;

endmodule

// File: tb/tb_btn_cmd.sv
// Self-checking bench for btn_cmd: directed vector table plus randomized run against a history-based model.
module tb_btn_cmd;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn;
    logic       ack;
    logic       valid;
    logic [2:0] code;
    logic [4:0] db_btn;

    int total = 0;
    int bad   = 0;

    btn_cmd #(.DB_CYCLES(DB), .DB_W(8), .REPEAT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .ack(ack),
        .valid(valid), .code(code), .db_btn(db_btn)
    );

    always #5 clk = ~clk;

    // Reference: debounced bit flips once the last DB samples seen through the
    // two-flop delay all disagree with it; the handshake is tracked as flags.
    logic [4:0] hist[$];
    logic [4:0] m_db, m_dbd;
    logic       m_pend, m_wait;
    logic [2:0] m_code;

    function automatic logic [2:0] prio(input logic [4:0] p);
        if (p[4]) return 3'd5;
        if (p[0]) return 3'd1;
        if (p[1]) return 3'd2;
        if (p[2]) return 3'd3;
        if (p[3]) return 3'd4;
        return 3'd0;
    endfunction

    function automatic void m_reset();
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back(5'd0);
        m_db = '0; m_dbd = '0; m_pend = 0; m_wait = 0; m_code = '0;
    endfunction

    function automatic void m_edge(input logic [4:0] b, input logic a);
        logic [4:0] p, ndb;
        bit all;
        p = m_db & ~m_dbd;
        if (m_pend) begin
            if (a) begin m_pend = 0; m_wait = (m_db != 0); end
        end else if (m_wait) begin
            if (m_db == 0) m_wait = 0;
        end else if (p != 0) begin
            m_code = prio(p); m_pend = 1;
        end
        ndb = m_db;
        for (int i = 0; i < 5; i++) begin
            all = 1;
            for (int k = 0; k < DB; k++)
                if (hist[hist.size()-2-k][i] == m_db[i]) all = 0;
            if (all) ndb[i] = ~m_db[i];
        end
        m_dbd = m_db;
        m_db  = ndb;
        hist.push_back(b);
        void'(hist.pop_front());
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; applies inputs for one edge and checks against the model.
    task automatic step(input logic [4:0] b, input logic a);
        btn = b; ack = a;
        @(posedge clk);
        m_edge(b, a);
        #1;
        chk("model_valid", 32'(valid), 32'(m_pend));
        chk("model_code", 32'(code), 32'(m_code));
        chk("model_db", 32'(db_btn), 32'(m_db));
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0] b;
        logic       a;
        int         n;
        logic       ev;
        logic [2:0] ec;
        logic [4:0] edb;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [4:0] rb;
        int hold;

        vt = '{
            // single press, ack 3 cycles after valid
            '{5'h01, 1'b0, 5,  1'b0, 3'd5, 5'h00},
            '{5'h01, 1'b0, 1,  1'b0, 3'd5, 5'h01},
            '{5'h01, 1'b0, 1,  1'b1, 3'd1, 5'h01},
            '{5'h01, 1'b0, 2,  1'b1, 3'd1, 5'h01},
            '{5'h01, 1'b1, 1,  1'b0, 3'd1, 5'h01},
            '{5'h01, 1'b0, 10, 1'b0, 3'd1, 5'h01},
            '{5'h00, 1'b0, 5,  1'b0, 3'd1, 5'h01},
            '{5'h00, 1'b0, 1,  1'b0, 3'd1, 5'h00},
            '{5'h00, 1'b0, 4,  1'b0, 3'd1, 5'h00},
            // glitch of 3 cycles
            '{5'h04, 1'b0, 3,  1'b0, 3'd1, 5'h00},
            '{5'h00, 1'b0, 8,  1'b0, 3'd1, 5'h00},
            // center + down together
            '{5'h12, 1'b0, 6,  1'b0, 3'd1, 5'h12},
            '{5'h12, 1'b0, 1,  1'b1, 3'd5, 5'h12},
            '{5'h12, 1'b1, 1,  1'b0, 3'd5, 5'h12},
            '{5'h00, 1'b0, 6,  1'b0, 3'd5, 5'h00},
            '{5'h00, 1'b0, 3,  1'b0, 3'd5, 5'h00},
            // press while pending is dropped, then must fully release
            '{5'h04, 1'b0, 7,  1'b1, 3'd3, 5'h04},
            '{5'h0C, 1'b0, 7,  1'b1, 3'd3, 5'h0C},
            '{5'h0C, 1'b1, 1,  1'b0, 3'd3, 5'h0C},
            '{5'h08, 1'b0, 10, 1'b0, 3'd3, 5'h08},
            '{5'h00, 1'b0, 6,  1'b0, 3'd3, 5'h00},
            '{5'h00, 1'b0, 2,  1'b0, 3'd3, 5'h00},
            '{5'h08, 1'b0, 6,  1'b0, 3'd3, 5'h08},
            '{5'h08, 1'b0, 1,  1'b1, 3'd4, 5'h08},
            '{5'h08, 1'b1, 1,  1'b0, 3'd4, 5'h08},
            '{5'h08, 1'b0, 12, 1'b0, 3'd4, 5'h08},
            '{5'h00, 1'b0, 8,  1'b0, 3'd4, 5'h00}
        };

        // reset with all buttons held
        rst_n = 1'b0; btn = 5'h1F; ack = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_db", 32'(db_btn), 32'd0);
        rst_n = 1'b1;
        repeat (5) step(5'h1F, 1'b0);
        chk("rst_db_e5", 32'(db_btn), 32'h00);
        step(5'h1F, 1'b0);
        chk("rst_db_e6", 32'(db_btn), 32'h1F);
        chk("rst_valid_e6", 32'(valid), 32'd0);
        step(5'h1F, 1'b0);
        chk("rst_valid_e7", 32'(valid), 32'd1);
        chk("rst_code_e7", 32'(code), 32'd5);
        step(5'h1F, 1'b1);
        chk("rst_ack", 32'(valid), 32'd0);
        repeat (8) step(5'h00, 1'b0);

        foreach (vt[i]) begin
            for (int j = 0; j < vt[i].n; j++) step(vt[i].b, vt[i].a);
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d_code", i), 32'(code), 32'(vt[i].ec));
            chk($sformatf("vec%0d_db", i), 32'(db_btn), 32'(vt[i].edb));
        end

        // randomized run, with one reset in the middle
        rb = '0; hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_valid", 32'(valid), 32'd0);
                chk("midrst_code", 32'(code), 32'd0);
                chk("midrst_db", 32'(db_btn), 32'd0);
                m_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0:       rb = 5'h00;
                    1:       rb = 5'(1 << $urandom_range(0, 4));
                    2:       rb = 5'($urandom_range(0, 31));
                    default: rb = rb;
                endcase
                hold = $urandom_range(1, 12);
            end
            hold--;
            step(rb, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
